// File: rtl/spi_mm_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SPI bridge between two requesters.
// One transaction in flight; reads are tracked with a timeout that returns an error word.
module spi_mm_arbiter #(
    parameter int              ADDR_W       = 10,
    parameter int              DATA_W       = 32,
    parameter int              RD_TIMEOUT   = 1024,
    parameter logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic [ADDR_W-1:0]     rq0_address,
    input  logic                  rq0_read,
    input  logic                  rq0_write,
    input  logic [DATA_W-1:0]     rq0_writedata,
    input  logic [DATA_W/8-1:0]   rq0_byteenable,
    output logic                  rq0_waitrequest,
    output logic [DATA_W-1:0]     rq0_readdata,
    output logic                  rq0_readdatavalid,
    input  logic [ADDR_W-1:0]     rq1_address,
    input  logic                  rq1_read,
    input  logic                  rq1_write,
    input  logic [DATA_W-1:0]     rq1_writedata,
    input  logic [DATA_W/8-1:0]   rq1_byteenable,
    output logic                  rq1_waitrequest,
    output logic [DATA_W-1:0]     rq1_readdata,
    output logic                  rq1_readdatavalid,
    output logic [ADDR_W-1:0]     spi_address,
    output logic                  spi_read,
    output logic                  spi_write,
    output logic [DATA_W-1:0]     spi_writedata,
    output logic [DATA_W/8-1:0]   spi_byteenable,
    output logic                  spi_burstcount,
    input  logic                  spi_waitrequest,
    input  logic [DATA_W-1:0]     spi_readdata,
    input  logic                  spi_readdatavalid,
    output logic                  timeout_err
);

    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, CMD, RDWAIT} state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic              terr_q, terr_d;

    logic req0, req1, g_read, g_write, accept;

    assign req0    = rq0_read | rq0_write;
    assign req1    = rq1_read | rq1_write;
    assign g_read  = grant_q ? rq1_read  : rq0_read;
    assign g_write = grant_q ? rq1_write : rq0_write;
    assign accept  = (state_q == CMD) && !spi_waitrequest;

    // Only the granted requester's command reaches the bridge; write wins over read.
    assign spi_address    = grant_q ? rq1_address    : rq0_address;
    assign spi_writedata  = grant_q ? rq1_writedata  : rq0_writedata;
    assign spi_byteenable = grant_q ? rq1_byteenable : rq0_byteenable;
    assign spi_write      = (state_q == CMD) && g_write;
    assign spi_read       = (state_q == CMD) && g_read && !g_write;
    assign spi_burstcount = 1'b1;

    assign rq0_waitrequest   = !(accept && !grant_q);
    assign rq1_waitrequest   = !(accept && grant_q);
    assign rq0_readdata      = rdata0_q;
    assign rq1_readdata      = rdata1_q;
    assign rq0_readdatavalid = rvalid0_q;
    assign rq1_readdatavalid = rvalid1_q;
    assign timeout_err       = terr_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        terr_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    grant_d = !last_grant_q;
                    state_d = CMD;
                end else if (req0 || req1) begin
                    grant_d = req1;
                    state_d = CMD;
                end
            end
            CMD: begin
                if (!spi_waitrequest) begin
                    last_grant_d = grant_q;
                    if (g_write) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RDWAIT;
                        cnt_d   = '0;
                    end
                end
            end
            RDWAIT: begin
                // A real response takes precedence over a timeout in the same cycle.
                if (spi_readdatavalid) begin
                    if (grant_q) begin
                        rdata1_d  = spi_readdata;
                        rvalid1_d = 1'b1;
                    end else begin
                        rdata0_d  = spi_readdata;
                        rvalid0_d = 1'b1;
                    end
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
                    if (grant_q) begin
                        rdata1_d  = TIMEOUT_DATA;
                        rvalid1_d = 1'b1;
                    end else begin
                        rdata0_d  = TIMEOUT_DATA;
                        rvalid0_d = 1'b1;
                    end
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            terr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            terr_q       <= terr_d;
        end
    end

endmodule
